// File: rtl/alu_pipe.sv
// Pipelined WIDTH-bit ALU with valid/ready handshakes, a stored carry for ADC chains
// and an iterative shift-add multiplier; one operation in flight, all outputs registered.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             err,
    output logic             busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_ADC = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    localparam int MSB = WIDTH - 1;
    localparam int CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    state_t               state_r;
    logic                 carry_r;
    logic                 out_valid_r;
    logic [WIDTH-1:0]     result_r;
    logic                 cout_r;
    logic                 zero_r;
    logic                 neg_r;
    logic                 ovf_r;
    logic                 err_r;

    logic [2*WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [CW-1:0]        cnt_r;

    logic                 accept_s;
    logic                 carry_in_s;
    logic [WIDTH:0]       add_s;
    logic [WIDTH:0]       sub_s;
    logic [WIDTH-1:0]     alu_res_s;
    logic                 alu_cout_s;
    logic                 alu_ovf_s;
    logic                 alu_err_s;
    logic                 carry_upd_s;
    logic [2*WIDTH-1:0]   product_s;

    assign in_ready  = (state_r == ST_IDLE) && (!out_valid_r || out_ready);
    assign accept_s  = in_valid && in_ready;
    assign busy      = (state_r != ST_IDLE);
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign cout      = cout_r;
    assign zero      = zero_r;
    assign neg       = neg_r;
    assign ovf       = ovf_r;
    assign err       = err_r;

    // Partial product including the current multiplier bit; on the last step this is the full product.
    assign product_s = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});

    // Single-cycle ALU evaluation of the presented operands.
    always_comb begin
        carry_in_s  = (op == OP_ADC) ? carry_r : 1'b0;
        add_s       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in_s};
        sub_s       = {1'b0, a} - {1'b0, b};
        alu_res_s   = {WIDTH{1'b0}};
        alu_cout_s  = 1'b0;
        alu_ovf_s   = 1'b0;
        alu_err_s   = 1'b0;
        carry_upd_s = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                alu_res_s   = add_s[WIDTH-1:0];
                alu_cout_s  = add_s[WIDTH];
                alu_ovf_s   = (a[MSB] == b[MSB]) && (add_s[MSB] != a[MSB]);
                carry_upd_s = 1'b1;
            end
            OP_SUB: begin
                alu_res_s   = sub_s[WIDTH-1:0];
                alu_cout_s  = sub_s[WIDTH];
                alu_ovf_s   = (a[MSB] != b[MSB]) && (sub_s[MSB] != a[MSB]);
                carry_upd_s = 1'b1;
            end
            OP_AND:  alu_res_s = a & b;
            OP_OR:   alu_res_s = a | b;
            OP_XOR:  alu_res_s = a ^ b;
            OP_MUL:  alu_res_s = {WIDTH{1'b0}};
            default: alu_err_s = 1'b1;
        endcase
    end

    // Control FSM together with the output/flag registers and the stored carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            carry_r     <= 1'b0;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            zero_r      <= 1'b0;
            neg_r       <= 1'b0;
            ovf_r       <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (op == OP_MUL)) begin
                        state_r     <= ST_MUL;
                        out_valid_r <= 1'b0;
                    end else if (accept_s) begin
                        out_valid_r <= 1'b1;
                        result_r    <= alu_res_s;
                        cout_r      <= alu_cout_s;
                        zero_r      <= (alu_res_s == {WIDTH{1'b0}}) || alu_err_s;
                        neg_r       <= alu_res_s[MSB];
                        ovf_r       <= alu_ovf_s;
                        err_r       <= alu_err_s;
                        if (carry_upd_s) begin
                            carry_r <= alu_cout_s;
                        end
                    end else if (out_valid_r && out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                ST_MUL: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r     <= ST_HOLD;
                        out_valid_r <= 1'b1;
                        result_r    <= product_s[WIDTH-1:0];
                        cout_r      <= |product_s[2*WIDTH-1:WIDTH];
                        zero_r      <= (product_s[WIDTH-1:0] == {WIDTH{1'b0}});
                        neg_r       <= product_s[MSB];
                        ovf_r       <= 1'b0;
                        err_r       <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Shift-add multiplier datapath: one multiplier bit consumed per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (accept_s && (op == OP_MUL)) begin
            mcand_r  <= {{WIDTH{1'b0}}, a};
            mplier_r <= b;
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (state_r == ST_MUL) begin
            acc_r    <= product_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CW'(1);
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe (WIDTH=8): hand-computed vectors checked with
// immediate assertions, ending in a single summary line.
module tb_alu_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       cout;
    logic       zero;
    logic       neg;
    logic       ovf;
    logic       err;
    logic       busy;

    int vectors;
    int miscompares;

    alu_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        in_valid = v;
        op       = o;
        a        = x;
        b        = y;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] r, input logic c, input logic z,
                           input logic n, input logic v, input logic e);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".result"}, {24'd0, result}, {24'd0, r});
        chk({tag, ".cout"}, {31'd0, cout}, {31'd0, c});
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, z});
        chk({tag, ".neg"}, {31'd0, neg}, {31'd0, n});
        chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, v});
        chk({tag, ".err"}, {31'd0, err}, {31'd0, e});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        out_ready   = 1'b1;
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        #1;
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.result", {24'd0, result}, 32'd0);
        chk("rst.zero", {31'd0, zero}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.err", {31'd0, err}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rel.in_ready", {31'd0, in_ready}, 32'd1);

        // ADD / SUB issued back-to-back with the consumer always ready
        drive(1'b1, 3'b000, 8'hF0, 8'h20);
        step();
        chk_out("add", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'b001, 8'h05, 8'h07);
        step();
        chk_out("sub1", 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 3'b001, 8'h80, 8'h01);
        step();
        chk_out("sub2", 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Carry chain through carry_q
        drive(1'b1, 3'b000, 8'hFF, 8'h01);
        step();
        chk_out("chain.add", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'b101, 8'h00, 8'h00);
        step();
        chk_out("chain.adc1", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'b010, 8'h0F, 8'hF0);
        step();
        chk_out("chain.and", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'b101, 8'h01, 8'h01);
        step();
        chk_out("chain.adc2", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        step();
        chk("drain.valid", {31'd0, out_valid}, 32'd0);

        // MUL 0x10 x 0x11 with a second op held on the input
        drive(1'b1, 3'b110, 8'h10, 8'h11);
        step();
        drive(1'b1, 3'b000, 8'h03, 8'h04);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("mul.busy%0d", i), {31'd0, busy}, 32'd1);
            chk($sformatf("mul.in_ready%0d", i), {31'd0, in_ready}, 32'd0);
            chk($sformatf("mul.valid%0d", i), {31'd0, out_valid}, 32'd0);
            step();
        end
        chk_out("mul", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hold.busy", {31'd0, busy}, 32'd1);
        chk("hold.in_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("hold_exit.valid", {31'd0, out_valid}, 32'd0);
        chk("hold_exit.busy", {31'd0, busy}, 32'd0);
        chk("hold_exit.in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk_out("post_mul.add", 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        step();
        chk("drain2.valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: XOR result must hold while the consumer stalls
        out_ready = 1'b0;
        drive(1'b1, 3'b100, 8'hAA, 8'hFF);
        step();
        drive(1'b1, 3'b011, 8'h0F, 8'h30);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp.in_ready%0d", i), {31'd0, in_ready}, 32'd0);
            chk_out($sformatf("bp.xor%0d", i), 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk_out("bp.or", 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Set carry_q, then reset in the middle of a MUL
        drive(1'b1, 3'b000, 8'hFF, 8'h01);
        step();
        chk_out("pre_rst.add", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'b110, 8'h03, 8'h05);
        step();
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        step();
        step();
        step();
        chk("mid_mul.busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst.valid", {31'd0, out_valid}, 32'd0);
        chk("mrst.result", {24'd0, result}, 32'd0);
        chk("mrst.cout", {31'd0, cout}, 32'd0);
        chk("mrst.zero", {31'd0, zero}, 32'd0);
        chk("mrst.busy", {31'd0, busy}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("mrel.in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 3'b111, 8'h12, 8'h34);
        step();
        chk_out("op111", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("op111.busy", {31'd0, busy}, 32'd0);
        drive(1'b1, 3'b101, 8'h00, 8'h00);
        step();
        chk_out("rst_carry.adc", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        step();
        chk("final.valid", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
